// File: rtl/mem_align_pkg.sv
// Shared types for mem_align: size encodings, byte-lane enables, pipeline-stage record.
// Also holds the pure lane-mapping helpers used by the request stage.
package mem_align_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic       vld;
        logic       we;
        size_e      size;
        logic       sgn;
        logic [1:0] off;
    } stage_t;

    function automatic logic is_legal(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            SZ_WORD: return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return BE_BYTE << off;
            SZ_HALF: return BE_HALF << {off[1], 1'b0};
            SZ_WORD: return BE_WORD;
            default: return BE_NONE;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input size_e size, input logic [1:0] off,
                                               input logic [31:0] d);
        case (size)
            SZ_BYTE: return {24'd0, d[7:0]} << {off, 3'b000};
            SZ_HALF: return {16'd0, d[15:0]} << {off[1], 4'b0000};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/ld_ext.sv
// Load extractor: picks the addressed lane(s) of a read word and sign/zero-extends them.
// Purely combinational; sits between the memory-stage registers and the response register.
module ld_ext
    import mem_align_pkg::*;
(
    input  size_e       size_i,
    input  logic        sgn_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        half_v = rdata_i[{off_i[1], 4'b0000} +: 16];
        data_o = rdata_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sgn_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{16{sgn_i & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_align.sv
// Byte/half/word load-store aligner: request -> memory strobes next cycle -> response 3 cycles after request.
// Accepts one request per cycle with no backpressure; responses return in request order.
module mem_align
    import mem_align_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              err,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data
);

    size_e             req_sz;
    logic              req_ok;
    stage_t            s1_d, s1_q, s2_d, s2_q;
    logic              mem_en_d, mem_en_q, mem_we_d, mem_we_q, err_d, err_q;
    logic [3:0]        mem_be_d, mem_be_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [31:0]       mem_wdata_d, mem_wdata_q;
    logic              rsp_valid_d, rsp_valid_q;
    logic [31:0]       rsp_data_d, rsp_data_q, ld_data;

    always_comb begin
        req_sz      = size_e'(req_size);
        req_ok      = req_valid & is_legal(req_sz, req_addr[1:0]);

        s1_d.vld    = req_valid;
        s1_d.we     = req_we;
        s1_d.size   = req_sz;
        s1_d.sgn    = req_signed;
        s1_d.off    = req_addr[1:0];

        mem_en_d    = req_ok;
        mem_we_d    = req_ok & req_we;
        mem_be_d    = req_ok ? lane_be(req_sz, req_addr[1:0]) : BE_NONE;
        err_d       = req_valid & ~req_ok;
        mem_addr_d  = req_ok ? {req_addr[ADDR_W-1:2], 2'b00} : mem_addr_q;
        mem_wdata_d = (req_ok & req_we) ? lane_wdata(req_sz, req_addr[1:0], req_wdata)
                                        : mem_wdata_q;

        // Only legal loads continue past the memory stage; stores and errors drain here.
        s2_d        = s1_q;
        s2_d.vld    = s1_q.vld & ~s1_q.we & is_legal(s1_q.size, s1_q.off);

        rsp_valid_d = s2_q.vld & ~s2_q.we;
        rsp_data_d  = rsp_valid_d ? ld_data : rsp_data_q;
    end

    ld_ext u_ld_ext (
        .size_i  (s2_q.size),
        .sgn_i   (s2_q.sgn),
        .off_i   (s2_q.off),
        .rdata_i (mem_rdata),
        .data_o  (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= BE_NONE;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_align.sv
// Directed bench for mem_align: inputs driven and outputs sampled on the falling clock edge.
// Memory is modelled by driving mem_rdata in the cycle after each load strobe.
module tb_mem_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        mem_en, mem_we, err, rsp_valid;
    logic [31:0] mem_addr, mem_wdata, rsp_data;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    mem_align #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .err        (err),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF);
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata, err, rsp_valid, rsp_data} !== 104'd0) begin
            n_bad++;
            $display("FAIL reset_initial: outputs %h required 0",
                     {mem_en, mem_we, mem_addr, mem_be, mem_wdata, err, rsp_valid, rsp_data});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata, err, rsp_valid, rsp_data} !== 104'd0) begin
            n_bad++;
            $display("FAIL reset_clocked: outputs %h required 0",
                     {mem_en, mem_we, mem_addr, mem_be, mem_wdata, err, rsp_valid, rsp_data});
        end
        reset = 1'b0;
        req_valid = 1'b0;
        mem_rdata = 32'd0;
    endtask

    task automatic test_store();
        logic [31:0] addr_t [2] = '{32'h13, 32'h06};
        logic [31:0] wd_t   [2] = '{32'h0000_00A5, 32'hFFFF_BEEF};
        logic [1:0]  sz_t   [2] = '{2'b00, 2'b01};
        logic [3:0]  be_t   [2] = '{4'b1000, 4'b1100};
        logic [31:0] ma_t   [2] = '{32'h10, 32'h04};
        logic [31:0] mw_t   [2] = '{32'hA500_0000, 32'hBEEF_0000};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, sz_t[i], 1'b0, addr_t[i], wd_t[i]);
            @(negedge clk);
            req_valid = 1'b0;
            n_cmp++;
            if ({mem_en, mem_we, mem_be, err} !== {2'b11, be_t[i], 1'b0}) begin
                n_bad++;
                $display("FAIL store%0d_ctl: en/we/be/err %b required %b", i,
                         {mem_en, mem_we, mem_be, err}, {2'b11, be_t[i], 1'b0});
            end
            n_cmp++;
            if ({mem_addr, mem_wdata} !== {ma_t[i], mw_t[i]}) begin
                n_bad++;
                $display("FAIL store%0d_data: addr/wdata %h required %h", i,
                         {mem_addr, mem_wdata}, {ma_t[i], mw_t[i]});
            end
            repeat (2) begin
                @(negedge clk);
                n_cmp++;
                if (rsp_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL store%0d_norsp: rsp_valid %b required 0", i, rsp_valid);
                end
            end
        end
    endtask

    task automatic test_idle();
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1234_5678);
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_be, err, rsp_valid} !== 8'd0) begin
            n_bad++;
            $display("FAIL idle_ctl: en/we/be/err/rsp %b required 0",
                     {mem_en, mem_we, mem_be, err, rsp_valid});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== {32'h04, 32'hBEEF_0000}) begin
            n_bad++;
            $display("FAIL idle_hold: addr/wdata %h required %h",
                     {mem_addr, mem_wdata}, {32'h04, 32'hBEEF_0000});
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz_t  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
        logic        sg_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad_t  [6] = '{32'h2, 32'h2, 32'h2, 32'h4, 32'h0, 32'h7};
        logic [31:0] rd_t  [6] = '{32'h1280_FF34, 32'h1280_FF34, 32'h8001_1234,
                                   32'h89AB_CDEF, 32'h8001_1234, 32'h7F00_0000};
        logic [3:0]  be_t  [6] = '{4'b0100, 4'b0100, 4'b1100, 4'b1111, 4'b0011, 4'b1000};
        logic [31:0] ex_t  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                   32'h89AB_CDEF, 32'h0000_1234, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, sz_t[i], sg_t[i], ad_t[i], 32'hFFFF_FFFF);
            @(negedge clk);
            req_valid = 1'b0;
            n_cmp++;
            if ({mem_en, mem_we, mem_be, err, mem_addr} !== {2'b10, be_t[i], 1'b0, ad_t[i] & ~32'h3}) begin
                n_bad++;
                $display("FAIL load%0d_mem: en/we/be/err/addr %h required %h", i,
                         {mem_en, mem_we, mem_be, err, mem_addr},
                         {2'b10, be_t[i], 1'b0, ad_t[i] & ~32'h3});
            end
            @(negedge clk);
            mem_rdata = rd_t[i];
            @(negedge clk);
            mem_rdata = 32'd0;
            n_cmp++;
            if ({rsp_valid, rsp_data} !== {1'b1, ex_t[i]}) begin
                n_bad++;
                $display("FAIL load%0d_rsp: valid/data %h required %h", i,
                         {rsp_valid, rsp_data}, {1'b1, ex_t[i]});
            end
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_data} !== {1'b0, ex_t[i]}) begin
                n_bad++;
                $display("FAIL load%0d_hold: valid/data %h required %h", i,
                         {rsp_valid, rsp_data}, {1'b0, ex_t[i]});
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz_t [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] ad_t [3] = '{32'h6, 32'h0, 32'h5};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, sz_t[i], 1'b1, ad_t[i], 32'd0);
            @(negedge clk);
            req_valid = 1'b0;
            mem_rdata = 32'hA5A5_A5A5;
            n_cmp++;
            if ({mem_en, mem_we, mem_be, err} !== 7'b00_0000_1) begin
                n_bad++;
                $display("FAIL err%0d_pulse: en/we/be/err %b required 0000001", i,
                         {mem_en, mem_we, mem_be, err});
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_cmp++;
                if ({err, rsp_valid} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL err%0d_drain%0d: err/rsp_valid %b required 00", i, c,
                             {err, rsp_valid});
                end
            end
            mem_rdata = 32'd0;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'd0);
        n_cmp++;
        if ({mem_en, mem_we, mem_be, mem_addr} !== {2'b10, 4'b0010, 32'h20}) begin
            n_bad++;
            $display("FAIL b2b_lb_mem: en/we/be/addr %h required %h",
                     {mem_en, mem_we, mem_be, mem_addr}, {2'b10, 4'b0010, 32'h20});
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        mem_rdata = 32'h0000_A700;
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h50, 32'h1122_3344);
        mem_rdata = 32'h9ABC_0000;
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'hFFFF_FFA7}) begin
            n_bad++;
            $display("FAIL b2b_rsp_lb: valid/data %h required %h", {rsp_valid, rsp_data},
                     {1'b1, 32'hFFFF_FFA7});
        end
        @(negedge clk);
        req_valid = 1'b0;
        mem_rdata = 32'hCAFE_F00D;
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000_9ABC}) begin
            n_bad++;
            $display("FAIL b2b_rsp_lh: valid/data %h required %h", {rsp_valid, rsp_data},
                     {1'b1, 32'h0000_9ABC});
        end
        n_cmp++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !==
            {2'b11, 4'b1111, 32'h50, 32'h1122_3344}) begin
            n_bad++;
            $display("FAIL b2b_sw_mem: en/we/be/addr/wdata %h required %h",
                     {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
                     {2'b11, 4'b1111, 32'h50, 32'h1122_3344});
        end
        @(negedge clk);
        mem_rdata = 32'd0;
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'hCAFE_F00D}) begin
            n_bad++;
            $display("FAIL b2b_rsp_lw: valid/data %h required %h", {rsp_valid, rsp_data},
                     {1'b1, 32'hCAFE_F00D});
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_sw_norsp: rsp_valid %b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h1, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata, err, rsp_valid, rsp_data} !== 104'd0) begin
            n_bad++;
            $display("FAIL midop_reset: outputs %h required 0",
                     {mem_en, mem_we, mem_addr, mem_be, mem_wdata, err, rsp_valid, rsp_data});
        end
        @(negedge clk);
        mem_rdata = 32'h0000_8000;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 1'b1, 32'h8, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if ({mem_en, mem_we, mem_be, err, mem_addr, rsp_valid} !== {2'b10, 4'b1111, 1'b0, 32'h8, 1'b0}) begin
            n_bad++;
            $display("FAIL midop_first_req: en/we/be/err/addr/rsp %h required %h",
                     {mem_en, mem_we, mem_be, err, mem_addr, rsp_valid},
                     {2'b10, 4'b1111, 1'b0, 32'h8, 1'b0});
        end
        @(negedge clk);
        mem_rdata = 32'h8765_4321;
        n_cmp++;
        if ({err, rsp_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL midop_no_stale: err/rsp_valid %b required 00", {err, rsp_valid});
        end
        @(negedge clk);
        mem_rdata = 32'd0;
        n_cmp++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'h8765_4321}) begin
            n_bad++;
            $display("FAIL midop_rsp: valid/data %h required %h", {rsp_valid, rsp_data},
                     {1'b1, 32'h8765_4321});
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_idle();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
